// File: rtl/l1_cache.sv
// l1_cache: direct-mapped, write-back, write-allocate L1 data cache.
// The CPU side takes 32-bit word requests; the memory side moves whole 256-bit lines.
// Hits complete combinationally in the request cycle. A miss first writes back a
// dirty victim (if there is one), then fills the line, then re-evaluates as a hit.
module l1_cache #(
   parameter int NUM_SETS = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  mem_address,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [3:0]   mem_byte_enable,
   input  logic [31:0]  mem_wdata,
   output logic [31:0]  mem_rdata,
   output logic         mem_resp,
   input  logic [255:0] pmem_rdata,
   input  logic         pmem_resp,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   output logic         pmem_read,
   output logic         pmem_write
);
   localparam int IDX = $clog2(NUM_SETS);
   localparam int TAG = 27 - IDX;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

   state_t               state_q, state_d;
   logic                 pmem_read_q, pmem_write_q;
   logic [NUM_SETS-1:0]  valid_q, valid_d, dirty_q, dirty_d;
   logic [TAG-1:0]       tag_q  [NUM_SETS];
   logic [255:0]         data_q [NUM_SETS];
   logic [TAG-1:0]       tag_d;
   logic [255:0]         data_d;
   logic                 data_we, tag_we;

   // Address decode: the byte offset is irrelevant to word-granular requests.
   logic [IDX-1:0] idx;
   logic [TAG-1:0] addr_tag;
   logic [2:0]     word;
   logic           unused_byte_ofs;
   assign idx             = mem_address[4+IDX:5];
   assign addr_tag        = mem_address[31:5+IDX];
   assign word            = mem_address[4:2];
   assign unused_byte_ofs = ^mem_address[1:0];

   logic         req, hit;
   logic [255:0] cur_line, merged;
   assign req      = mem_read | mem_write;
   assign cur_line = data_q[idx];
   assign hit      = (state_q == IDLE) & req & valid_q[idx] & (tag_q[idx] == addr_tag);

   // CPU response: the selected word of the hit line, forced to zero otherwise.
   always_comb begin
      mem_resp  = hit;
      mem_rdata = hit ? cur_line[32*int'(word) +: 32] : 32'h0;
   end

   // Byte-lane merge of the write data into the resident line.
   always_comb begin
      merged = cur_line;
      for (int b = 0; b < 4; b++)
         if (mem_byte_enable[b])
            merged[32*int'(word) + 8*b +: 8] = mem_wdata[8*b +: 8];
   end

   // Next-state, line-update and status-bit logic for the miss FSM.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      data_d  = merged;
      tag_d   = addr_tag;
      data_we = 1'b0;
      tag_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (hit && mem_write) begin
               data_we      = 1'b1;
               dirty_d[idx] = 1'b1;
            end else if (req && !hit) begin
               state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: if (pmem_resp) state_d = ALLOCATE;
         ALLOCATE: begin
            if (pmem_resp) begin
               data_d       = pmem_rdata;
               data_we      = 1'b1;
               tag_we       = 1'b1;
               valid_d[idx] = 1'b1;
               dirty_d[idx] = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state plus registered pmem strobes; reset abandons any line transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pmem_read_q  <= (state_d == ALLOCATE);
         pmem_write_q <= (state_d == WRITEBACK);
      end
   end

   // Line status bits; cleared on reset so every line misses afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Data and tag storage; contents are meaningless until valid is set.
   always_ff @(posedge clk) begin
      if (data_we) data_q[idx] <= data_d;
      if (tag_we)  tag_q[idx]  <= tag_d;
   end

   // Memory-side address/data: victim line in WRITEBACK, requested line in ALLOCATE.
   always_comb begin
      pmem_read    = pmem_read_q;
      pmem_write   = pmem_write_q;
      pmem_address = 32'h0;
      pmem_wdata   = '0;
      if (state_q == WRITEBACK) begin
         pmem_address = {tag_q[idx], idx, 5'b0};
         pmem_wdata   = cur_line;
      end else if (state_q == ALLOCATE) begin
         pmem_address = {addr_tag, idx, 5'b0};
      end
   end
endmodule

// File: tb/tb_l1_cache.sv
// tb_l1_cache: directed table plus random ops against a flat-memory reference model.
module tb_l1_cache;
   localparam int NS = 8;

   logic         clk = 0, rst_n = 0;
   logic [31:0]  mem_address = 0;
   logic         mem_read = 0, mem_write = 0;
   logic [3:0]   mem_byte_enable = 0;
   logic [31:0]  mem_wdata = 0;
   logic [31:0]  mem_rdata;
   logic         mem_resp;
   logic [255:0] pmem_rdata = '0;
   logic         pmem_resp = 0;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic         pmem_read, pmem_write;

   l1_cache #(.NUM_SETS(NS)) dut (
      .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_read(mem_read),
      .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_rdata(pmem_rdata),
      .pmem_resp(pmem_resp), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write));

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   int lat = 3;
   int pcnt = 0, rd_cycles = 0, proto_bad = 0;
   logic [31:0] last_rd_addr = 0, last_wb_addr = 0;

   // Physical memory: lines keyed by line address, default pattern when untouched.
   logic [255:0] pmem [int unsigned];

   function automatic logic [255:0] dflt_line(int unsigned la);
      logic [255:0] r;
      for (int w = 0; w < 8; w++) r[32*w +: 32] = 32'hC0DE_0000 ^ (la << 3) ^ w;
      return r;
   endfunction

   function automatic logic [255:0] get_line(int unsigned la);
      if (pmem.exists(la)) return pmem[la];
      return dflt_line(la);
   endfunction

   // Memory responder with latency lat, plus protocol monitors.
   always @(negedge clk) begin
      if (pmem_read || pmem_write) begin
         pcnt = pcnt + 1;
         if (pmem_read) begin rd_cycles = rd_cycles + 1; last_rd_addr = pmem_address; end
         if (pcnt >= lat) begin
            pmem_resp = 1;
            pcnt = 0;
            if (pmem_write) begin
               pmem[pmem_address >> 5] = pmem_wdata;
               last_wb_addr = pmem_address;
            end else begin
               pmem_rdata = get_line(pmem_address >> 5);
            end
         end else pmem_resp = 0;
      end else begin
         pmem_resp = 0;
         pcnt = 0;
      end
      if (pmem_read && pmem_write) proto_bad++;
      if (pmem_address[4:0] != 0) proto_bad++;
      if (!pmem_read && !pmem_write && (pmem_address != 0 || pmem_wdata != 0)) proto_bad++;
      if (!mem_resp && mem_rdata != 0) proto_bad++;
   end

   // Reference model: architectural word memory plus direct-mapped residency.
   bit          m_valid [NS];
   bit          m_dirty [NS];
   int unsigned m_tag   [NS];
   logic [31:0] truth [int unsigned];

   function automatic logic [31:0] truth_rd(logic [31:0] a);
      logic [255:0] l;
      if (truth.exists(a >> 2)) return truth[a >> 2];
      l = get_line(a >> 5);
      return l[32*a[4:2] +: 32];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
      truth.delete();
   endtask

   task automatic model_step(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] wd,
                             output logic [31:0] exp_rd, output int exp_cyc);
      int unsigned ix, tg;
      bit h;
      logic [31:0] v;
      ix = (a >> 5) % NS;
      tg = a / (32 * NS);
      h = m_valid[ix] && (m_tag[ix] == tg);
      exp_cyc = h ? 1 : ((m_valid[ix] && m_dirty[ix]) ? 2*lat + 2 : lat + 2);
      exp_rd = truth_rd(a);
      if (!h) begin m_valid[ix] = 1; m_tag[ix] = tg; m_dirty[ix] = 0; end
      if (wr) begin
         v = exp_rd;
         for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
         truth[a >> 2] = v;
         m_dirty[ix] = 1;
      end
      if (rd) ; // read-only ops change nothing beyond residency
   endtask

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Present a request at posedge+1 and wait for mem_resp; leaves strobes driven.
   task automatic exec(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd,
                       output logic [31:0] rdat, output int cyc);
      bit got;
      mem_read = rd; mem_write = wr; mem_address = a;
      mem_byte_enable = be; mem_wdata = wd;
      cyc = 0; rdat = 0; got = 0; rd_cycles = 0;
      while (!got && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (mem_resp) begin got = 1; rdat = mem_rdata; end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL timeout: no mem_resp for addr %0h", a);
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic rd, wr; logic [31:0] a; logic [3:0] be; logic [31:0] wd;
      logic chk; logic [31:0] exp_rd; int exp_cyc;
   } vec_t;
   vec_t tbl[14];

   initial begin
      logic [31:0] rdat, erd;
      int cyc, ecyc;
      tbl[0]  = '{1,0,32'h040,4'h0,32'h0,         1,32'h1111_1111,5};
      tbl[1]  = '{1,0,32'h040,4'h0,32'h0,         1,32'h1111_1111,1};
      tbl[2]  = '{0,1,32'h040,4'h5,32'hAABB_CCDD, 0,32'h0,        1};
      tbl[3]  = '{1,0,32'h040,4'h0,32'h0,         1,32'h11BB_11DD,1};
      tbl[4]  = '{1,0,32'h044,4'h0,32'h0,         1,32'h1111_1111,1};
      tbl[5]  = '{1,0,32'h140,4'h0,32'h0,         1,32'hC0DE_0050,8};
      tbl[6]  = '{0,1,32'h064,4'hF,32'h1234_5678, 0,32'h0,        5};
      tbl[7]  = '{1,0,32'h064,4'h0,32'h0,         1,32'h1234_5678,1};
      tbl[8]  = '{1,0,32'h068,4'h0,32'h0,         1,32'hC0DE_001A,1};
      tbl[9]  = '{1,0,32'h140,4'h0,32'h0,         1,32'hC0DE_0050,1};
      tbl[10] = '{1,1,32'h140,4'hF,32'hDEAD_BEEF, 0,32'h0,        1};
      tbl[11] = '{1,0,32'h140,4'h0,32'h0,         1,32'hDEAD_BEEF,1};
      tbl[12] = '{1,0,32'h040,4'h0,32'h0,         1,32'h11BB_11DD,8};
      tbl[13] = '{1,0,32'h140,4'h0,32'h0,         1,32'hDEAD_BEEF,5};

      pmem[2] = {8{32'h1111_1111}};
      model_reset();

      // Reset state, with a read already presented: nothing may respond.
      mem_read = 1; mem_address = 32'h40;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_resp", mem_resp, 0);
      check("rst_pmem_read", pmem_read, 0);
      check("rst_pmem_write", pmem_write, 0);
      check("rst_pmem_address", pmem_address, 0);
      check("rst_pmem_wdata", pmem_wdata, 0);
      mem_read = 0;
      rst_n = 1;
      @(posedge clk); #1;

      // Directed table.
      for (int i = 0; i < 14; i++) begin
         model_step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].be, tbl[i].wd, erd, ecyc);
         exec(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].be, tbl[i].wd, rdat, cyc);
         check($sformatf("vec%0d_cycles", i), cyc, tbl[i].exp_cyc);
         if (tbl[i].chk) check($sformatf("vec%0d_rdata", i), rdat, tbl[i].exp_rd);
         if (i == 0) begin
            check("fill_rd_cycles", rd_cycles, 3);
            check("fill_rd_addr", last_rd_addr, 32'h40);
         end
         if (i == 5) begin
            check("evict_wb_addr", last_wb_addr, 32'h40);
            check("evict_wb_word0", pmem[2][31:0], 32'h11BB_11DD);
            check("evict_rd_addr", last_rd_addr, 32'h140);
         end
         if (i == 6) check("wmiss_rd_addr", last_rd_addr, 32'h60);
      end
      mem_read = 0; mem_write = 0;
      @(posedge clk); #1;

      // Reset in the middle of ALLOCATE: strobe drops at once, line stays invalid.
      lat = 6;
      mem_read = 1; mem_address = 32'h80;
      repeat (3) @(negedge clk);
      check("mid_alloc_pmem_read_before", pmem_read, 1);
      rst_n = 0;
      #1;
      check("mid_alloc_pmem_read_async", pmem_read, 0);
      check("mid_alloc_mem_resp", mem_resp, 0);
      mem_read = 0;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
      lat = 3;
      @(posedge clk); #1;
      model_step(1, 0, 32'h80, 4'h0, 32'h0, erd, ecyc);
      exec(1, 0, 32'h80, 4'h0, 32'h0, rdat, cyc);
      check("post_rst_cycles", cyc, 5);
      check("post_rst_rdata", rdat, erd);

      // Random traffic over a small conflicting address pool.
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a, wd;
         logic [3:0] be;
         logic rd, wr;
         int k;
         lat = $urandom_range(1, 4);
         a = (($urandom_range(0, 3) * NS + $urandom_range(0, NS-1)) * 32) + $urandom_range(0, 7) * 4;
         k = $urandom_range(0, 3);
         rd = (k != 2);
         wr = (k >= 2);
         be = 4'($urandom);
         wd = $urandom;
         model_step(rd, wr, a, be, wd, erd, ecyc);
         exec(rd, wr, a, be, wd, rdat, cyc);
         check($sformatf("rand%0d_cycles", n), cyc, ecyc);
         if (!wr) check($sformatf("rand%0d_rdata@%0h", n, a), rdat, erd);
      end
      mem_read = 0; mem_write = 0;
      @(posedge clk); #1;

      check("protocol_violations", proto_bad, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
